dec_to_bin: RTL

Sequential BCD-to-binary converter: accepts four packed BCD digits and produces the equivalent unsigned binary value using the reverse shift-and-subtract-3 algorithm, one bit per clock. It sits on the input path of the processor (switch/keypad decimal entry feeding the 32-bit datapath) and is the counterpart of the combinational binary-to-BCD display converter. A start/busy/done handshake lets a controller FSM issue one conversion at a time.

---
 rtl/dec_to_bin_pkg.sv | 31 +++
 rtl/dec_to_bin_bcd_digit_adjust.sv | 18 +
 rtl/dec_to_bin.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dec_to_bin_pkg.sv
// -----------------------------------------------------------------------------
// dec_to_bin_pkg
// Shared types and constants for the sequential BCD-to-binary converter.
//   state_t    : controller states (IDLE, SHIFT, DONE)
//   NUM_DIGITS : number of packed BCD digits accepted per conversion
//   BCD_WIDTH  : width of the packed BCD operand / binary accumulator
//   ITERATIONS : shift iterations per conversion (one bit per clock)
//   bcd_invalid: true when any 4-bit digit of a packed BCD word exceeds 9
// -----------------------------------------------------------------------------
package dec_to_bin_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_WIDTH  = 16;
  localparam int ITERATIONS = 16;

  function automatic logic bcd_invalid(input logic [BCD_WIDTH-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (word[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/dec_to_bin_bcd_digit_adjust.sv
// -----------------------------------------------------------------------------
// bcd_digit_adjust
// Combinational per-digit correction for reverse double-dabble: a digit that
// received a shifted-in weight of 8 actually represents 5, so subtract 3.
//   digit_in  : 4-bit BCD digit after the shift
//   digit_out : digit_in - 3 when digit_in >= 8, else digit_in (4-bit, no borrow)
// -----------------------------------------------------------------------------
module bcd_digit_adjust (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'd8) digit_out = digit_in - 4'd3;
  end

endmodule

// File: rtl/dec_to_bin.sv
// -----------------------------------------------------------------------------
// dec_to_bin
// Sequential BCD-to-binary converter (reverse shift-and-subtract-3), one bit
// per clock. 16 SHIFT cycles plus one DONE cycle; result and done pulse appear
// 17 cycles after the start-sampling edge.
//
// Ports:
//   clock   : rising-edge clock
//   resetn  : asynchronous active-low reset
//   start   : conversion request, sampled only in IDLE
//   ten_0..ten_3 : BCD ones / tens / hundreds / thousands digits
//   binary  : registered result (zero-extended), held until next result
//   busy    : high whenever the controller is not in IDLE
//   done    : one-cycle pulse coinciding with a new binary value
//   err     : registered with binary; invalid-digit flag
//
// Optional feature: define BCD_DIGIT_CHECK_EN to flag digits > 9 at capture;
// a flagged conversion then returns binary = 0 with err = 1. Without the macro
// err is tied low and invalid digits simply run through the algorithm.
// -----------------------------------------------------------------------------
module dec_to_bin
  import dec_to_bin_pkg::*;
#(
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [3:0]           ten_0,
  input  logic [3:0]           ten_1,
  input  logic [3:0]           ten_2,
  input  logic [3:0]           ten_3,
  output logic [OUT_WIDTH-1:0] binary,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  state_t                 state_q, state_d;
  logic [BCD_WIDTH-1:0]   bcd_q, bcd_d;
  logic [BCD_WIDTH-1:0]   acc_q, acc_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   binary_q, binary_d;
  logic                   done_q, done_d;

  // {bcd,acc} shifted right as one 32-bit unit: bcd[0] drops into acc[15].
  logic [2*BCD_WIDTH-1:0] shift_w;
  logic [BCD_WIDTH-1:0]   bcd_adj;

  assign shift_w = {bcd_q, acc_q} >> 1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit_in  (shift_w[BCD_WIDTH + 4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic flag_q, flag_d;
  logic err_q, err_d;
`endif

  always_comb begin
    state_d  = state_q;
    bcd_d    = bcd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    binary_d = binary_q;
    done_d   = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
    flag_d   = flag_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bcd_d   = {ten_3, ten_2, ten_1, ten_0};
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
          flag_d  = bcd_invalid({ten_3, ten_2, ten_1, ten_0});
`endif
        end
      end
      SHIFT: begin
        bcd_d = bcd_adj;
        acc_d = shift_w[BCD_WIDTH-1:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITERATIONS - 1)) state_d = DONE;
      end
      DONE: begin
        binary_d = OUT_WIDTH'(acc_q);
        done_d   = 1'b1;
        state_d  = IDLE;
`ifdef BCD_DIGIT_CHECK_EN
        err_d    = flag_q;
        if (flag_q) binary_d = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      bcd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      binary_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcd_q    <= bcd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      binary_q <= binary_d;
      done_q   <= done_d;
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign binary = binary_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

endmodule
